// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer helpers shared by the write-side and read-side FIFO control blocks
package fifo_pkg;
    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) b = b ^ (g >> i);
        return b;
    endfunction
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary conversion (XOR prefix from the MSB down)
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end
endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-domain pointer, full/almost-full, fill level and sticky overflow for the async FIFO
module wptr_full_ctrl
    import fifo_pkg::bin2gray;
    import fifo_pkg::fifo_depth;
#(
    parameter int ADDR_W   = 4,
    parameter int AFULL_TH = 2
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic              winc,
    input  logic [ADDR_W:0]   wq2_rptr,
    input  logic              wclr_ovf,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              wovf
);
    localparam int DEPTH = fifo_depth(ADDR_W);
    logic [ADDR_W:0] wbin, wbin_n, wgray_n, rbin, diff;
    logic            wen;
    gray2bin #(.W(ADDR_W + 1)) u_g2b (.gray(wq2_rptr), .bin(rbin));
    assign wen     = winc & ~wfull;
    assign wbin_n  = wbin + (ADDR_W + 1)'(wen);
    assign wgray_n = (ADDR_W + 1)'(bin2gray(32'(wbin_n)));
    // occupancy against the lagging read pointer: never optimistic
    assign diff    = wbin_n - rbin;
    assign waddr   = wbin[ADDR_W-1:0];
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            wovf         <= 1'b0;
        end else begin
            wbin         <= wbin_n;
            wptr         <= wgray_n;
            wfull        <= wgray_n == {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};
            walmost_full <= diff >= (ADDR_W + 1)'(DEPTH - AFULL_TH);
            wlevel       <= diff;
            wovf         <= (winc & wfull) | (wovf & ~wclr_ovf);
        end
    end
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: random and directed stimulus, queue scoreboard against a counting model
module tb_wptr_full_ctrl;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 2;

    logic          wclk, wrst, winc, wclr_ovf;
    logic [AW:0]   wq2_rptr;
    logic [AW-1:0] waddr, waddr0;
    logic [AW:0]   wptr, wptr0, wlevel, wlevel0;
    logic          wfull, wfull0, walmost_full, walmost_full0, wovf, wovf0;

    wptr_full_ctrl #(.ADDR_W(AW), .AFULL_TH(AF)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr), .wclr_ovf(wclr_ovf),
        .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
        .wlevel(wlevel), .wovf(wovf));

    wptr_full_ctrl #(.ADDR_W(AW), .AFULL_TH(0)) dut0 (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr), .wclr_ovf(wclr_ovf),
        .waddr(waddr0), .wptr(wptr0), .wfull(wfull0), .walmost_full(walmost_full0),
        .wlevel(wlevel0), .wovf(wovf0));

    typedef struct {
        int waddr; int wptr; int full; int af; int af0; int full0; int level; int ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0, fails = 0;
    // model state: total accepted writes, total reads seen, registered flags
    int   wcnt = 0, rd = 0;
    bit   m_full = 0, m_ovf = 0;

    initial begin
        wclk = 0;
        forever #5 wclk = ~wclk;
    end

    function automatic int gray(input int v);
        int m;
        m = v % (2 * DEPTH);
        return m ^ (m >> 1);
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        int   lvl;
        lvl     = wcnt - rd;
        e.waddr = wcnt % DEPTH;
        e.wptr  = gray(wcnt);
        e.full  = int'(m_full);
        e.af    = int'(lvl >= DEPTH - AF);
        e.af0   = int'(lvl >= DEPTH);
        e.full0 = int'(m_full);
        e.level = lvl;
        e.ovf   = int'(m_ovf);
        q.push_back(e);
    endtask

    task automatic cycle(input bit inc, input bit clr, input bit rd_step);
        @(negedge wclk);
        wrst = 0;
        if (rd_step && rd < wcnt) rd++;
        winc     = inc;
        wclr_ovf = clr;
        wq2_rptr = (AW + 1)'(gray(rd));
        m_ovf    = (inc && m_full) || (m_ovf && !clr);
        if (inc && !m_full) wcnt++;
        m_full   = (wcnt - rd) == DEPTH;
        push_expected();
    endtask

    task automatic async_reset();
        @(negedge wclk);
        #2 wrst = 1;
        #1;
        chk("async_rst_waddr", int'(waddr), 0);
        chk("async_rst_wptr", int'(wptr), 0);
        chk("async_rst_flags", int'({wfull, walmost_full, wovf}), 0);
        chk("async_rst_wlevel", int'(wlevel), 0);
        wcnt = 0; rd = 0; m_full = 0; m_ovf = 0;
        winc = 0; wclr_ovf = 0; wq2_rptr = '0;
        push_expected();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge wclk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("waddr", int'(waddr), e.waddr);
                chk("wptr", int'(wptr), e.wptr);
                chk("wfull", int'(wfull), e.full);
                chk("walmost_full", int'(walmost_full), e.af);
                chk("wlevel", int'(wlevel), e.level);
                chk("wovf", int'(wovf), e.ovf);
                chk("walmost_full_th0", int'(walmost_full0), e.af0);
                chk("wfull_th0", int'(wfull0), e.full0);
            end
        end
    end

    initial begin
        wrst = 1; winc = 0; wclr_ovf = 0; wq2_rptr = '0;
        #1;
        chk("reset_state", int'({waddr, wptr, wfull, walmost_full, wlevel, wovf}), 0);
        for (int i = 0; i < 8; i++) cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        cycle(1, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        for (int i = 0; i < 40; i++) cycle(i % 2 == 0, 0, i % 2 == 1);
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(3) != 0, $urandom_range(7) == 0, $urandom_range(1) == 1);
        async_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0);
        async_reset();
        cycle(1, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0);
        @(negedge wclk);
        @(negedge wclk);
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
